cpu_controller: RTL and testbench
=================================

CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in  input  16  instruction word; captured into the internal instruction register (IR).
REQ-004 load  input  1  IR load enable.
REQ-005 s  input  1  start: execute the instruction held in IR.
REQ-006 Z_out  input  3  datapath status: [0] zero, [1] negative, [2] overflow.
REQ-007 w  output  1  1 = idle in WAIT, ready for load/s.
REQ-008 vsel  output  2  register-file write-source select: 00 datapath_out, 10 sximm8.
REQ-009 readnum, writenum  output  3 each  register-file read and write addresses.
REQ-010 write, loada, loadb, loadc, loads  output  1 each  datapath strobes.
REQ-011 asel, bsel  output  1 each  operand selects: asel=1 forces A=0; bsel=1 selects sximm5.
REQ-012 shift, ALUop  output  2 each  shifter and ALU controls.
REQ-013 sximm8, sximm5  output  16 each  sign-extended IR[7:0] and IR[4:0].
REQ-014 branch_taken  output  1  one-cycle pulse: PC logic shall load PC+1+sximm8.
REQ-015 illegal  output  1  one-cycle pulse: undefined opcode.

Function
REQ-016 IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0], cond=IR[10:8].
REQ-017 IR shall load in on a clock edge with load=1 only while in WAIT; load shall be ignored in all other states.
REQ-018 sximm8, sximm5 and shift (=sh) shall be combinational from IR in every state.
REQ-019 States: WAIT, DECODE, GET_A, GET_B, ALU, WR_REG, WR_IMM, BRANCH.
REQ-020 WAIT: w=1; s=1 -> DECODE; s is ignored in every other state.
REQ-021 DECODE dispatch:
- 110/10 (MOV imm) -> WR_IMM.
- 110/00 (MOV shift) and 101/11 (MVN) -> GET_B.
- 101/00 (ADD), 101/01 (CMP), 101/10 (AND) -> GET_A.
- 001 with cond<=100 -> BRANCH.
- Anything else -> WAIT with illegal=1 for that cycle.
REQ-022 GET_A: readnum=Rn, loada=1 -> GET_B.
REQ-023 GET_B: readnum=Rm, loadb=1 -> ALU.
REQ-024 ALU: bsel=0.
- MOV shift: asel=1, ALUop=00, loadc=1 -> WR_REG.
- ADD/AND/MVN: asel=0 (MVN: don't-care), ALUop=op, loadc=1 -> WR_REG.
- CMP: asel=0, ALUop=01, loads=1, loadc=0 -> WAIT.
REQ-025 WR_REG: vsel=00, writenum=Rd, write=1 -> WAIT.
REQ-026 WR_IMM: vsel=10, writenum=Rn, write=1 -> WAIT.
REQ-027 BRANCH evaluates Z_out as sampled in this cycle, then -> WAIT:
- B: always taken.
- BEQ: taken if Z=1.
- BNE: taken if Z=0.
- BLT: taken if N!=V.
- BLE: taken if (N!=V) or Z=1.
- branch_taken=1 for this cycle only when taken.
REQ-028 Every output not driven by the current state shall take its idle value: strobes 0, vsel 00, readnum/writenum 000, asel 0, bsel 0, ALUop 00.
REQ-029 Latency from the s edge back to w=1: MOV imm 2 cycles; branch 2; illegal 1; MOV shift/MVN 4; CMP 4; ADD/AND 5.
REQ-030 Outputs shall be Moore-decoded from state and IR; no output depends combinationally on s or load.

Reset
REQ-031 rst_n=0 shall immediately force state=WAIT and IR=16'h0000, with all strobes, branch_taken and illegal at 0 and w=1, regardless of the current state.
REQ-032 Release of rst_n mid-instruction shall resume in WAIT; the aborted instruction shall produce no further write or loads.

Verification
REQ-033 load in=16'hD007, pulse s -> next cycle DECODE; following cycle write=1, vsel=10, writenum=0, sximm8=16'h0007; then w=1.
REQ-034 in=16'hA140 (ADD R2,R1,R0), s -> loada with readnum=1, then loadb with readnum=0, then loadc with ALUop=00, then write with writenum=2; w=1 five cycles after s.
REQ-035 in=16'hA900 (CMP R1,R0), s -> ALU cycle has loads=1, loadc=0, ALUop=01; write never asserted.
REQ-036 in=16'h2103 (BEQ) with Z_out=3'b001 -> branch_taken pulses once and sximm8=16'h0003; repeat with Z_out=3'b000 -> branch_taken stays 0.
REQ-037 in=16'h2380 (BLT, imm8=8'h80) with Z_out=3'b010 -> taken and sximm8=16'hFF80; in=16'hE000 -> illegal pulses one cycle after s, then w=1.
REQ-038 Mid-ADD at GET_B: assert load with a new in -> IR unchanged; assert rst_n=0 -> w=1 asynchronously with no write pulse.

Source files
------------

// File: rtl/cpu_controller_if.sv
// Controller <-> datapath/fetch bundle for cpu_controller.
// The slave side is the controller; the master side drives instructions and status.
interface cpu_controller_if;
   logic [15:0] in;
   logic        load;
   logic        s;
   logic [2:0]  Z_out;
   logic        w;
   logic [1:0]  vsel;
   logic [2:0]  readnum;
   logic [2:0]  writenum;
   logic        write;
   logic        loada;
   logic        loadb;
   logic        loadc;
   logic        loads;
   logic        asel;
   logic        bsel;
   logic [1:0]  shift;
   logic [1:0]  ALUop;
   logic [15:0] sximm8;
   logic [15:0] sximm5;
   logic        branch_taken;
   logic        illegal;

   modport master (
      output in, load, s, Z_out,
      input  w, vsel, readnum, writenum, write, loada, loadb, loadc, loads,
             asel, bsel, shift, ALUop, sximm8, sximm5, branch_taken, illegal
   );

   modport slave (
      input  in, load, s, Z_out,
      output w, vsel, readnum, writenum, write, loada, loadb, loadc, loads,
             asel, bsel, shift, ALUop, sximm8, sximm5, branch_taken, illegal
   );
endinterface

// File: rtl/cpu_controller.sv
// Multi-cycle instruction controller: holds the IR and sequences datapath strobes.
// All outputs are Moore-decoded from state and IR (branch_taken also reads Z_out).
module cpu_controller (
   input logic             clk,
   input logic             rst_n,
   cpu_controller_if.slave bus
);

   localparam logic [2:0] WAIT   = 3'd0;
   localparam logic [2:0] DECODE = 3'd1;
   localparam logic [2:0] GET_A  = 3'd2;
   localparam logic [2:0] GET_B  = 3'd3;
   localparam logic [2:0] ALU    = 3'd4;
   localparam logic [2:0] WR_REG = 3'd5;
   localparam logic [2:0] WR_IMM = 3'd6;
   localparam logic [2:0] BRANCH = 3'd7;

   logic [2:0]  state;
   logic [2:0]  next_state;
   logic [15:0] ir;

   logic [2:0] opcode;
   logic [1:0] op;
   logic [2:0] rn;
   logic [2:0] rd;
   logic [2:0] rm;
   logic [2:0] cond;

   assign opcode = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[10:8];
   assign rd     = ir[7:5];
   assign rm     = ir[2:0];
   assign cond   = ir[10:8];

   logic is_mov_imm;
   logic is_mov_sh;
   logic is_mvn;
   logic is_add;
   logic is_cmp;
   logic is_and;
   logic is_branch;

   assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
   assign is_mov_sh  = (opcode == 3'b110) && (op == 2'b00);
   assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
   assign is_add     = (opcode == 3'b101) && (op == 2'b00);
   assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);
   assign is_and     = (opcode == 3'b101) && (op == 2'b10);
   assign is_branch  = (opcode == 3'b001) && (cond <= 3'b100);

   assign bus.sximm8 = {{8{ir[7]}}, ir[7:0]};
   assign bus.sximm5 = {{11{ir[4]}}, ir[4:0]};
   assign bus.shift  = ir[4:3];

   // IR only accepts load while idle; reset clears it along with the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= WAIT;
         ir    <= '0;
      end else begin
         state <= next_state;
         if (state == WAIT && bus.load)
            ir <= bus.in;
      end
   end

   always_comb begin
      next_state = WAIT;
      case (state)
         WAIT:    next_state = bus.s ? DECODE : WAIT;
         DECODE: begin
            if (is_mov_imm)                   next_state = WR_IMM;
            else if (is_mov_sh || is_mvn)     next_state = GET_B;
            else if (is_add || is_cmp || is_and) next_state = GET_A;
            else if (is_branch)               next_state = BRANCH;
            else                              next_state = WAIT;
         end
         GET_A:   next_state = GET_B;
         GET_B:   next_state = ALU;
         ALU:     next_state = is_cmp ? WAIT : WR_REG;
         WR_REG:  next_state = WAIT;
         WR_IMM:  next_state = WAIT;
         BRANCH:  next_state = WAIT;
         default: next_state = WAIT;
      endcase
   end

   logic flag_z;
   logic flag_n;
   logic flag_v;
   logic taken;

   assign flag_z = bus.Z_out[0];
   assign flag_n = bus.Z_out[1];
   assign flag_v = bus.Z_out[2];

   always_comb begin
      taken = 1'b0;
      case (cond)
         3'b000:  taken = 1'b1;
         3'b001:  taken = flag_z;
         3'b010:  taken = !flag_z;
         3'b011:  taken = flag_n ^ flag_v;
         3'b100:  taken = (flag_n ^ flag_v) | flag_z;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      bus.w            = 1'b0;
      bus.vsel         = 2'b00;
      bus.readnum      = 3'b000;
      bus.writenum     = 3'b000;
      bus.write        = 1'b0;
      bus.loada        = 1'b0;
      bus.loadb        = 1'b0;
      bus.loadc        = 1'b0;
      bus.loads        = 1'b0;
      bus.asel         = 1'b0;
      bus.bsel         = 1'b0;
      bus.ALUop        = 2'b00;
      bus.branch_taken = 1'b0;
      bus.illegal      = 1'b0;
      case (state)
         WAIT:   bus.w = 1'b1;
         DECODE: bus.illegal = !(is_mov_imm || is_mov_sh || is_mvn || is_add ||
                                 is_cmp || is_and || is_branch);
         GET_A: begin
            bus.readnum = rn;
            bus.loada   = 1'b1;
         end
         GET_B: begin
            bus.readnum = rm;
            bus.loadb   = 1'b1;
         end
         ALU: begin
            if (is_mov_sh) begin
               bus.asel  = 1'b1;
               bus.ALUop = 2'b00;
               bus.loadc = 1'b1;
            end else if (is_cmp) begin
               bus.ALUop = 2'b01;
               bus.loads = 1'b1;
            end else begin
               bus.ALUop = op;
               bus.loadc = 1'b1;
            end
         end
         WR_REG: begin
            bus.vsel     = 2'b00;
            bus.writenum = rd;
            bus.write    = 1'b1;
         end
         WR_IMM: begin
            bus.vsel     = 2'b10;
            bus.writenum = rn;
            bus.write    = 1'b1;
         end
         BRANCH: bus.branch_taken = taken;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed vector table, corner-case sequences and
// randomized instructions checked against a per-instruction cycle-trace model.
module tb_cpu_controller;

   logic clk;
   logic rst_n;
   cpu_controller_if bus ();

   cpu_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       w;
      logic [1:0] vsel;
      logic [2:0] readnum;
      logic [2:0] writenum;
      logic       write;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic [1:0] alu_op;
      logic       branch_taken;
      logic       illegal;
   } outs_t;

   typedef struct {
      outs_t o;
      bit    dc_asel;
   } step_t;

   typedef struct {
      logic [15:0] ir;
      logic [2:0]  z;
      int          lat;
      logic [15:0] sx8;
      logic [15:0] sx5;
      logic [1:0]  sh;
      int          n_write;
      int          n_taken;
      int          n_ill;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;
   step_t exp_q[$];

   function automatic outs_t sample();
      outs_t o;
      o.w            = bus.w;
      o.vsel         = bus.vsel;
      o.readnum      = bus.readnum;
      o.writenum     = bus.writenum;
      o.write        = bus.write;
      o.loada        = bus.loada;
      o.loadb        = bus.loadb;
      o.loadc        = bus.loadc;
      o.loads        = bus.loads;
      o.asel         = bus.asel;
      o.bsel         = bus.bsel;
      o.alu_op       = bus.ALUop;
      o.branch_taken = bus.branch_taken;
      o.illegal      = bus.illegal;
      return o;
   endfunction

   function automatic void check_val(string name, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endfunction

   function automatic void check_outs(string name, outs_t got, outs_t exp, bit dc_asel);
      outs_t g;
      g = got;
      if (dc_asel) g.asel = exp.asel;
      n_checks++;
      if (g !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endfunction

   // Reference: expected output snapshot for each cycle after the s edge,
   // ending with the first idle (w=1) cycle.
   function automatic void build_trace(logic [15:0] ir, logic [2:0] z);
      outs_t o;
      step_t st;
      logic [2:0] opc;
      logic [1:0] op;
      logic [2:0] c;
      bit tk;
      opc = ir[15:13];
      op  = ir[12:11];
      c   = ir[10:8];
      exp_q.delete();
      st.dc_asel = 0;

      o = '0;
      if (!((opc == 3'b110 && (op == 2'b10 || op == 2'b00)) || opc == 3'b101 ||
            (opc == 3'b001 && c <= 3'd4)))
         o.illegal = 1'b1;
      st.o = o; exp_q.push_back(st);

      if (opc == 3'b110 && op == 2'b10) begin
         o = '0; o.vsel = 2'b10; o.writenum = ir[10:8]; o.write = 1'b1;
         st.o = o; exp_q.push_back(st);
      end else if (opc == 3'b001 && c <= 3'd4) begin
         case (c)
            3'd0:    tk = 1;
            3'd1:    tk = z[0];
            3'd2:    tk = !z[0];
            3'd3:    tk = z[1] != z[2];
            default: tk = (z[1] != z[2]) || z[0];
         endcase
         o = '0; o.branch_taken = tk;
         st.o = o; exp_q.push_back(st);
      end else if (opc == 3'b101 || (opc == 3'b110 && op == 2'b00)) begin
         if (opc == 3'b101 && op != 2'b11) begin
            o = '0; o.readnum = ir[10:8]; o.loada = 1'b1;
            st.o = o; exp_q.push_back(st);
         end
         o = '0; o.readnum = ir[2:0]; o.loadb = 1'b1;
         st.o = o; exp_q.push_back(st);
         o = '0;
         if (opc == 3'b110) begin
            o.asel = 1'b1; o.loadc = 1'b1;
         end else if (op == 2'b01) begin
            o.alu_op = 2'b01; o.loads = 1'b1;
         end else begin
            o.alu_op = op; o.loadc = 1'b1;
         end
         st.o = o; st.dc_asel = (opc == 3'b101 && op == 2'b11);
         exp_q.push_back(st);
         st.dc_asel = 0;
         if (!(opc == 3'b101 && op == 2'b01)) begin
            o = '0; o.writenum = ir[7:5]; o.write = 1'b1;
            st.o = o; exp_q.push_back(st);
         end
      end
      o = '0; o.w = 1'b1;
      st.o = o; exp_q.push_back(st);
   endfunction

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   // Loads ir while idle, then issues s; returns one step into DECODE.
   task automatic start_instr(logic [15:0] ir, logic [2:0] z);
      bus.in    = ir;
      bus.load  = 1'b1;
      bus.s     = 1'b0;
      bus.Z_out = z;
      go();
      bus.load = 1'b0;
      bus.s    = 1'b1;
      go();
      bus.s = 1'b0;
   endtask

   vec_t vecs[14];

   initial begin
      vecs[0]  = '{16'hD007, 3'b000, 2, 16'h0007, 16'h0007, 2'b00, 1, 0, 0};
      vecs[1]  = '{16'hA140, 3'b000, 5, 16'h0040, 16'h0000, 2'b00, 1, 0, 0};
      vecs[2]  = '{16'hA900, 3'b000, 4, 16'h0000, 16'h0000, 2'b00, 0, 0, 0};
      vecs[3]  = '{16'h2103, 3'b001, 2, 16'h0003, 16'h0003, 2'b00, 0, 1, 0};
      vecs[4]  = '{16'h2103, 3'b000, 2, 16'h0003, 16'h0003, 2'b00, 0, 0, 0};
      vecs[5]  = '{16'h2380, 3'b010, 2, 16'hFF80, 16'h0000, 2'b00, 0, 1, 0};
      vecs[6]  = '{16'hE000, 3'b000, 1, 16'h0000, 16'h0000, 2'b00, 0, 0, 1};
      vecs[7]  = '{16'h2205, 3'b000, 2, 16'h0005, 16'h0005, 2'b00, 0, 1, 0};
      vecs[8]  = '{16'h2205, 3'b001, 2, 16'h0005, 16'h0005, 2'b00, 0, 0, 0};
      vecs[9]  = '{16'h24FF, 3'b101, 2, 16'hFFFF, 16'hFFFF, 2'b11, 0, 1, 0};
      vecs[10] = '{16'h2500, 3'b000, 1, 16'h0000, 16'h0000, 2'b00, 0, 0, 1};
      vecs[11] = '{16'hB8F9, 3'b000, 4, 16'hFFF9, 16'hFFF9, 2'b11, 1, 0, 0};
      vecs[12] = '{16'hC010, 3'b000, 4, 16'h0010, 16'hFFF0, 2'b10, 1, 0, 0};
      vecs[13] = '{16'hB222, 3'b000, 5, 16'h0022, 16'h0002, 2'b00, 1, 0, 0};

      rst_n     = 1'b0;
      bus.in    = '0;
      bus.load  = 1'b0;
      bus.s     = 1'b0;
      bus.Z_out = '0;
      #2;
      begin
         outs_t idle;
         idle = '0; idle.w = 1'b1;
         check_outs("reset_outputs", sample(), idle, 0);
         check_val("reset_ir", {bus.sximm8, bus.sximm5}, 32'h0);
      end
      go();
      go();
      rst_n = 1'b1;
      go();

      // Directed table: latency, immediates and pulse counts per instruction
      for (int i = 0; i < 14; i++) begin
         int cyc, nw, nt, ni;
         start_instr(vecs[i].ir, vecs[i].z);
         check_val($sformatf("v%0d_sximm8", i), 32'(bus.sximm8), 32'(vecs[i].sx8));
         check_val($sformatf("v%0d_sximm5", i), 32'(bus.sximm5), 32'(vecs[i].sx5));
         check_val($sformatf("v%0d_shift", i), 32'(bus.shift), 32'(vecs[i].sh));
         cyc = 0; nw = 0; nt = 0; ni = 0;
         while (!bus.w && cyc < 20) begin
            nw += int'(bus.write);
            nt += int'(bus.branch_taken);
            ni += int'(bus.illegal);
            go();
            cyc++;
         end
         check_val($sformatf("v%0d_latency", i), 32'(cyc), 32'(vecs[i].lat));
         check_val($sformatf("v%0d_writes", i), 32'(nw), 32'(vecs[i].n_write));
         check_val($sformatf("v%0d_taken", i), 32'(nt), 32'(vecs[i].n_taken));
         check_val($sformatf("v%0d_illegal", i), 32'(ni), 32'(vecs[i].n_ill));
      end

      // Mid-ADD: load ignored at GET_B, then asynchronous reset in ALU
      start_instr(16'hA140, 3'b000);
      go();
      go();
      check_val("midadd_getb_loadb", 32'(bus.loadb), 32'd1);
      bus.in   = 16'hD0FF;
      bus.load = 1'b1;
      go();
      check_val("midadd_ir_kept", 32'(bus.sximm8), 32'h0040);
      check_val("midadd_alu_loadc", 32'(bus.loadc), 32'd1);
      rst_n = 1'b0;
      #1;
      check_val("midadd_rst_w", 32'(bus.w), 32'd1);
      check_val("midadd_rst_write", 32'(bus.write), 32'd0);
      check_val("midadd_rst_ir", 32'(bus.sximm8), 32'h0000);
      bus.load = 1'b0;
      go();
      rst_n = 1'b1;
      begin
         int nw, nl;
         nw = 0; nl = 0;
         for (int k = 0; k < 4; k++) begin
            go();
            nw += int'(bus.write);
            nl += int'(bus.loads);
            nl += int'(!bus.w);
         end
         check_val("postrst_no_write", 32'(nw), 32'd0);
         check_val("postrst_idle", 32'(nl), 32'd0);
      end

      // Random instructions against the trace model; s/load toggled while busy
      for (int t = 0; t < 60; t++) begin
         logic [15:0] ir;
         logic [2:0]  z;
         ir = 16'($urandom);
         z  = 3'($urandom);
         case ($urandom_range(0, 5))
            0:       ir[15:13] = 3'b110;
            1, 2:    ir[15:13] = 3'b101;
            3, 4:    ir[15:13] = 3'b001;
            default: ;
         endcase
         build_trace(ir, z);
         start_instr(ir, z);
         for (int k = 0; k < exp_q.size(); k++) begin
            check_outs($sformatf("rnd%0d_ir%h_c%0d", t, ir, k), sample(),
                       exp_q[k].o, exp_q[k].dc_asel);
            check_val($sformatf("rnd%0d_imm_c%0d", t, k),
                      {bus.sximm8[7:0], bus.sximm5[15:4], bus.shift, bus.sximm5[3:0]},
                      {ir[7:0], {12{ir[4]}}, ir[4:3], ir[3:0]});
            if (k < exp_q.size() - 1) begin
               bus.s    = 1'($urandom);
               bus.load = 1'($urandom);
               bus.in   = 16'($urandom);
               go();
            end
         end
         bus.s    = 1'b0;
         bus.load = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
